// File: rtl/jesd204b_pkg.sv
// jesd204b_pkg: shared state encodings and default parameters for the JESD204B link supervisor
package jesd204b_pkg;
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_PHY    = 3'd1,
        WAIT_SYSREF = 3'd2,
        WAIT_SYNC   = 3'd3,
        LINK_UP     = 3'd4,
        RESYNC      = 3'd5,
        FAULT       = 3'd6
    } state_t;
    localparam int DEF_TIMEOUT_CYC   = 4096;
    localparam int DEF_SYNC_STABLE   = 16;
    localparam int DEF_RST_PULSE_CYC = 32;
    localparam int DEF_ERR_WINDOW    = 1024;
    localparam int DEF_ERR_THRESH    = 8;
    localparam int DEF_MAX_RETRY     = 7;
endpackage

// File: rtl/jesd204b_err_window.sv
// jesd204b_err_window: counts RX error-counter changes per fixed window and flags a rate trip
module jesd204b_err_window import jesd204b_pkg::*; #(
    parameter int ERR_WINDOW = DEF_ERR_WINDOW,
    parameter int ERR_THRESH = DEF_ERR_THRESH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [31:0] err0,
    input  logic [31:0] err1,
    output logic        trip
);
    localparam int WW = $clog2(ERR_WINDOW);
    localparam int CW = $clog2(ERR_THRESH + 1);
    logic [31:0]   prev0_q, prev1_q;
    logic          hist_q;
    logic [WW-1:0] win_q, win_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          evt, wrap;
    // history is only trusted after its first load, so reset release never fakes an event
    assign evt  = hist_q && (err0 != prev0_q || err1 != prev1_q);
    assign wrap = win_q == WW'(ERR_WINDOW - 1);
    assign trip = evt && (int'(cnt_q) + 1 >= ERR_THRESH);
    always_comb begin
        win_d = clear || wrap ? '0 : win_q + WW'(1);
        cnt_d = clear || wrap ? '0 : cnt_q + CW'(evt);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            prev0_q <= '0;
            prev1_q <= '0;
            hist_q  <= 1'b0;
            win_q   <= '0;
            cnt_q   <= '0;
        end else begin
            prev0_q <= err0;
            prev1_q <= err1;
            hist_q  <= 1'b1;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/jesd204b_link_supervisor.sv
// jesd204b_link_supervisor: brings up a JESD204B link, watches it for loss or error bursts,
// and retries with a link_reset pulse until a retry budget is exhausted.
module jesd204b_link_supervisor import jesd204b_pkg::*; #(
    parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC,
    parameter int SYNC_STABLE   = DEF_SYNC_STABLE,
    parameter int RST_PULSE_CYC = DEF_RST_PULSE_CYC,
    parameter int ERR_WINDOW    = DEF_ERR_WINDOW,
    parameter int ERR_THRESH    = DEF_ERR_THRESH,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_fault,
    input  logic        phy_ready,
    input  logic        sysref,
    input  logic        adc_sync_b,
    input  logic        dac_sync_b,
    input  logic [31:0] err_link_rx0,
    input  logic [31:0] err_link_rx1,
    output logic        link_reset,
    output logic        link_up,
    output logic        fault,
    output logic [2:0]  state,
    output logic [3:0]  retry_cnt,
    output logic [15:0] resync_total
);
    localparam int TW = $clog2((TIMEOUT_CYC > RST_PULSE_CYC ? TIMEOUT_CYC : RST_PULSE_CYC) + 1);
    localparam int SW = $clog2(SYNC_STABLE + 1);
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [3:0]    retry_q, retry_d;
    logic [15:0]   total_q, total_d;
    logic          sysref_q, link_reset_q, link_up_q, fault_q;
    logic          trip, go_rs, timeout, both;
    jesd204b_err_window #(.ERR_WINDOW(ERR_WINDOW), .ERR_THRESH(ERR_THRESH)) u_err (
        .clk   (clk),
        .reset (reset),
        .clear (state_q != LINK_UP),
        .err0  (err_link_rx0),
        .err1  (err_link_rx1),
        .trip  (trip)
    );
    assign timeout = timer_q == TW'(TIMEOUT_CYC - 1);
    assign both    = adc_sync_b & dac_sync_b;
    always_comb begin
        state_d  = state_q;
        stable_d = '0;
        retry_d  = retry_q;
        total_d  = total_q;
        go_rs    = 1'b0;
        if (!enable) state_d = IDLE;
        else begin
            // success is tested before the timeout in every WAIT_* state
            case (state_q)
                IDLE:        state_d = WAIT_PHY;
                WAIT_PHY:    if (phy_ready) state_d = WAIT_SYSREF; else go_rs = timeout;
                WAIT_SYSREF: if (sysref && !sysref_q) state_d = WAIT_SYNC; else go_rs = timeout;
                WAIT_SYNC: begin
                    stable_d = both ? stable_q + SW'(1) : '0;
                    if (stable_q == SW'(SYNC_STABLE)) state_d = LINK_UP; else go_rs = timeout;
                end
                LINK_UP: begin
                    go_rs = !phy_ready || !both || trip;
                    if (!go_rs && timeout) retry_d = '0;
                end
                RESYNC:      if (timer_q == TW'(RST_PULSE_CYC - 1)) state_d = WAIT_PHY;
                FAULT: begin
                    if (clear_fault) begin
                        state_d = WAIT_PHY;
                        retry_d = '0;
                    end
                end
                default:     state_d = IDLE;
            endcase
            if (go_rs && retry_q == 4'(MAX_RETRY)) state_d = FAULT;
            else if (go_rs) begin
                state_d = RESYNC;
                retry_d = &retry_q ? retry_q : retry_q + 4'd1;
                total_d = &total_q ? total_q : total_q + 16'd1;
            end
        end
        if (state_d == IDLE) retry_d = '0;
        if (state_d != state_q) stable_d = '0;
        timer_d = state_d != state_q ? '0 : &timer_q ? timer_q : timer_q + TW'(1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            stable_q     <= '0;
            retry_q      <= '0;
            total_q      <= '0;
            sysref_q     <= 1'b0;
            link_reset_q <= 1'b0;
            link_up_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            stable_q     <= stable_d;
            retry_q      <= retry_d;
            total_q      <= total_d;
            sysref_q     <= sysref;
            link_reset_q <= state_d == RESYNC;
            link_up_q    <= state_d == LINK_UP;
            fault_q      <= state_d == FAULT;
        end
    end
    assign link_reset   = link_reset_q;
    assign link_up      = link_up_q;
    assign fault        = fault_q;
    assign state        = state_q;
    assign retry_cnt    = retry_q;
    assign resync_total = total_q;
endmodule

// File: tb/tb_jesd204b_link_supervisor.sv
// tb_jesd204b_link_supervisor: directed spec scenarios plus random traffic, scored against a reference model
module tb_jesd204b_link_supervisor;
    localparam int T = 64, S = 4, P = 8, W = 32, TH = 3, MR = 2;
    typedef struct packed {
        logic [2:0]  st;
        logic        lr;
        logic        lu;
        logic        f;
        logic [3:0]  rc;
        logic [15:0] rt;
    } obs_t;
    logic        clk, reset, enable, clear_fault, phy_ready, sysref, adc_sync_b, dac_sync_b;
    logic [31:0] err_link_rx0, err_link_rx1;
    logic        link_reset, link_up, fault;
    logic [2:0]  state;
    logic [3:0]  retry_cnt;
    logic [15:0] resync_total;
    int n_chk = 0, n_pass = 0;
    obs_t exp_q[$];
    int m_st, m_age, m_retry, m_total, m_hi;
    bit m_sys, m_hist;
    logic [31:0] m_e0, m_e1;
    int m_ev[$];
    jesd204b_link_supervisor #(
        .TIMEOUT_CYC(T), .SYNC_STABLE(S), .RST_PULSE_CYC(P),
        .ERR_WINDOW(W), .ERR_THRESH(TH), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_fault(clear_fault),
        .phy_ready(phy_ready), .sysref(sysref), .adc_sync_b(adc_sync_b), .dac_sync_b(dac_sync_b),
        .err_link_rx0(err_link_rx0), .err_link_rx1(err_link_rx1),
        .link_reset(link_reset), .link_up(link_up), .fault(fault), .state(state),
        .retry_cnt(retry_cnt), .resync_total(resync_total)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // Reference: state plus time spent in it; WAIT_SYNC tracks when the current high run began,
    // LINK_UP keeps the ages of error events and groups them by age/W.
    task automatic model_step();
        int nxt, n;
        bit fail, evt, both;
        obs_t o;
        if (reset) begin
            m_st = 0; m_age = 0; m_retry = 0; m_total = 0; m_hi = -1;
            m_sys = 0; m_hist = 0; m_e0 = 0; m_e1 = 0;
            m_ev.delete();
        end else begin
            evt  = m_hist && (err_link_rx0 != m_e0 || err_link_rx1 != m_e1);
            both = adc_sync_b && dac_sync_b;
            nxt  = m_st;
            fail = 0;
            if (!enable) nxt = 0;
            else begin
                case (m_st)
                    0: nxt = 1;
                    1: if (phy_ready) nxt = 2; else fail = (m_age == T - 1);
                    2: if (sysref && !m_sys) nxt = 3; else fail = (m_age == T - 1);
                    3: if (m_hi >= 0 && m_age - m_hi >= S) nxt = 4; else fail = (m_age == T - 1);
                    4: begin
                        n = 0;
                        foreach (m_ev[i]) if (m_ev[i] / W == m_age / W) n++;
                        fail = !phy_ready || !both || (evt && n + 1 >= TH);
                        if (evt) m_ev.push_back(m_age);
                        if (!fail && m_age + 1 >= T) m_retry = 0;
                    end
                    5: if (m_age == P - 1) nxt = 1;
                    6: if (clear_fault) begin nxt = 1; m_retry = 0; end
                    default: nxt = 0;
                endcase
                if (fail && m_retry == MR) nxt = 6;
                else if (fail) begin
                    nxt = 5;
                    m_retry = m_retry < 15 ? m_retry + 1 : 15;
                    m_total = m_total < 65535 ? m_total + 1 : 65535;
                end
            end
            if (nxt == 0) m_retry = 0;
            if (m_st == 3 && nxt == 3) m_hi = !both ? -1 : (m_hi < 0 ? m_age : m_hi);
            else m_hi = -1;
            if (nxt != 4 || m_st != 4) m_ev.delete();
            m_age = nxt != m_st ? 0 : m_age + 1;
            m_st = nxt;
            m_sys = sysref; m_e0 = err_link_rx0; m_e1 = err_link_rx1; m_hist = 1;
        end
        o.st = 3'(m_st); o.lr = m_st == 5; o.lu = m_st == 4; o.f = m_st == 6;
        o.rc = 4'(m_retry); o.rt = 16'(m_total);
        exp_q.push_back(o);
    endtask
    task automatic step();
        model_step();
        @(negedge clk);
    endtask
    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask
    initial begin
        obs_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {state, link_reset, link_up, fault, retry_cnt, resync_total};
                n_chk++;
                if (g === e) n_pass++;
                else $display("FAIL scoreboard t=%0t got st=%0d lr=%0b lu=%0b f=%0b rc=%0d rt=%0d expected st=%0d lr=%0b lu=%0b f=%0b rc=%0d rt=%0d",
                    $time, g.st, g.lr, g.lu, g.f, g.rc, g.rt, e.st, e.lr, e.lu, e.f, e.rc, e.rt);
            end
        end
    end
    task automatic bring_up();
        enable = 0;
        step();
        enable = 1; phy_ready = 1; adc_sync_b = 1; dac_sync_b = 1; clear_fault = 0;
        for (int i = 0; i < 300 && m_st != 4; i++) begin
            sysref = (i % 16) == 3;
            step();
        end
        sysref = 0;
        chk("bring_up_link_up", link_up, 1);
    endtask
    initial begin
        int lr, cnt, tot;
        bit quiet;
        reset = 1; enable = 0; clear_fault = 0; phy_ready = 0; sysref = 0;
        adc_sync_b = 0; dac_sync_b = 0; err_link_rx0 = 0; err_link_rx1 = 0;
        @(negedge clk);
        repeat (3) step();
        chk("reset_state", state, 0);
        chk("reset_total", resync_total, 0);
        reset = 0; enable = 1;
        for (int c = 0; c < 35; c++) begin
            phy_ready = c >= 10; sysref = c == 20; adc_sync_b = c >= 30; dac_sync_b = c >= 30;
            step();
            if (c == 33) chk("nominal_not_yet_up", link_up, 0);
        end
        chk("nominal_link_up_c35", link_up, 1);
        chk("nominal_retry", retry_cnt, 0);
        sysref = 0;
        for (int a = 0; a < 260; a++) begin
            if (a < 192 ? (a % 32 == 5 || a % 32 == 20) : (a == 195 || a == 202 || a == 209))
                err_link_rx0 = err_link_rx0 + 1;
            step();
            if (a == 191) chk("err_two_per_window_up", link_up, 1);
            if (a == 209) begin
                chk("err_three_trip_state", state, 5);
                chk("err_three_trip_retry", retry_cnt, 1);
            end
        end
        bring_up();
        tot = m_total;
        dac_sync_b = 0; enable = 0;
        step();
        chk("prio_idle", state, 0);
        chk("prio_no_resync", resync_total, tot);
        chk("prio_link_reset", link_reset, 0);
        dac_sync_b = 1;
        reset = 1;
        step();
        reset = 0; enable = 1; phy_ready = 0; lr = 0;
        for (int i = 0; i < 220; i++) begin
            step();
            lr += int'(link_reset);
            if (i == 99) begin
                chk("timeout_pulse_width", lr, 8);
                chk("timeout_retry", retry_cnt, 1);
                chk("timeout_total", resync_total, 1);
            end
        end
        chk("fault_flag", fault, 1);
        chk("fault_state", state, 6);
        chk("fault_link_reset", link_reset, 0);
        clear_fault = 1;
        step();
        clear_fault = 0;
        chk("clear_fault_state", state, 1);
        chk("clear_fault_retry", retry_cnt, 0);
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 3; i++) begin
            step();
            if (link_reset) cnt++;
        end
        chk("mid_resync_reached", cnt, 3);
        reset = 1;
        step();
        reset = 0;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_link_reset", link_reset, 0);
        chk("mid_rst_link_up", link_up, 0);
        chk("mid_rst_fault", fault, 0);
        chk("mid_rst_retry", retry_cnt, 0);
        chk("mid_rst_total", resync_total, 0);
        for (int i = 0; i < 4000; i++) begin
            quiet = ((i / 250) % 2) == 1;
            reset = $urandom_range(0, 499) == 0;
            enable = $urandom_range(0, 99) != 0;
            clear_fault = $urandom_range(0, 19) == 0;
            phy_ready = $urandom_range(0, quiet ? 399 : 49) != 0;
            sysref = $urandom_range(0, 9) == 0;
            adc_sync_b = $urandom_range(0, quiet ? 399 : 39) != 0;
            dac_sync_b = $urandom_range(0, quiet ? 399 : 39) != 0;
            if ($urandom_range(0, quiet ? 11 : 24) == 0) err_link_rx0 = err_link_rx0 + $urandom_range(1, 5);
            if ($urandom_range(0, quiet ? 11 : 24) == 0) err_link_rx1 = err_link_rx1 + $urandom_range(1, 5);
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
